key_events: RTL and testbench



---
 rtl/key_events.sv | 175 +++++++++++++++++
 tb/tb_key_events.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_events.sv
`default_nettype none
// ============================================================================
//  Module      : key_events
//  Description : Per-key debounce filter and press/release event FIFO that
//                sits directly downstream of the TM1638 LED&Key driver. Each
//                of the eight raw key levels is filtered by a persistence
//                counter. Every change of a debounced level becomes one
//                {press, key} event. Events are queued in a small
//                first-word-fall-through FIFO with a valid/ready interface.
//  Ports       : clock, reset       - master clock, synchronous active-high reset
//                keys[7:0]          - raw key levels (1 = pressed)
//                keys_stable[7:0]   - debounced key levels
//                event_valid        - FIFO head holds an event
//                event_key[2:0]     - key index of the head event
//                event_press        - 1 = press, 0 = release
//                event_ready        - consumer accepts the head event
//                event_count        - number of queued events
//                overflow           - sticky flag, an event was dropped
//                clear_overflow     - clears overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module key_events #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [7:0]                    keys,
    output logic [7:0]                    keys_stable,
    output logic                          event_valid,
    output logic [2:0]                    event_key,
    output logic                          event_press,
    input  logic                          event_ready,
    output logic [$clog2(FIFO_DEPTH):0]   event_count,
    output logic                          overflow,
    input  logic                          clear_overflow
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FCNT_W-1:0] c_FULL    = FCNT_W'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Debounce
    // ------------------------------------------------------------------
    logic [7:0]       r_stable;
    logic [7:0]       w_flip;
    logic [CNT_W-1:0] r_cnt [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_key
            // A flip needs DEBOUNCE_CYCLES consecutive differing edges: the
            // counter walks 0..DEBOUNCE_CYCLES-1 and the next differing edge flips.
            assign w_flip[gi] = (keys[gi] != r_stable[gi]) && (r_cnt[gi] == c_CNT_MAX);

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_cnt[gi] <= '0;
                end else if (keys[gi] == r_stable[gi]) begin
                    r_cnt[gi] <= '0;
                end else if (r_cnt[gi] == c_CNT_MAX) begin
                    r_cnt[gi] <= '0;
                end else begin
                    r_cnt[gi] <= r_cnt[gi] + 1'b1;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pending events and priority drain (lowest key index first)
    // ------------------------------------------------------------------
    logic [7:0] r_pending;
    logic [7:0] r_pend_type;
    logic [7:0] w_drain_oh;
    logic [2:0] w_drain_idx;
    logic       w_drain_valid;
    logic       w_drain_type;

    always_comb begin
        // x & -x isolates the lowest set bit
        w_drain_oh    = r_pending & (~r_pending + 8'd1);
        w_drain_valid = |r_pending;
        w_drain_type  = |(r_pend_type & w_drain_oh);
        w_drain_idx   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_drain_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stable    <= '0;
            r_pending   <= '0;
            r_pend_type <= '0;
        end else begin
            r_stable    <= r_stable ^ w_flip;
            // A key never flips while its own pending bit is still set, so
            // clearing the drained bit and setting new ones cannot collide.
            r_pending   <= (r_pending & ~w_drain_oh) | w_flip;
            r_pend_type <= (r_pend_type & ~w_flip) | (keys & w_flip);
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [3:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr;
    logic [PTR_W-1:0]  r_rd;
    logic [FCNT_W-1:0] r_count;
    logic              r_overflow;
    logic              w_nonempty;
    logic              w_pop;
    logic              w_space;
    logic              w_push;

    assign w_nonempty = (r_count != '0);
    assign w_pop      = w_nonempty && event_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge
    assign w_space    = (r_count != c_FULL) || w_pop;
    assign w_push     = w_drain_valid && w_space;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Setting wins over clearing on the same edge
            if (w_drain_valid && !w_space) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Storage needs no reset: the outputs are gated by the entry count
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr] <= {w_drain_type, w_drain_idx};
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign keys_stable = r_stable;
    assign event_valid = w_nonempty;
    assign event_key   = w_nonempty ? r_mem[r_rd][2:0] : 3'd0;
    assign event_press = w_nonempty ? r_mem[r_rd][3]   : 1'b0;
    assign event_count = r_count;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_key_events.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_events
//  Description : Self-checking bench for key_events (DEBOUNCE_CYCLES = 8,
//                FIFO_DEPTH = 4). Expected events are queued when key
//                activity is driven and compared when the DUT pops them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_events;

    localparam int DEB   = 8;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] keys;
    logic [7:0] keys_stable;
    logic       event_valid;
    logic [2:0] event_key;
    logic       event_press;
    logic       event_ready;
    logic [2:0] event_count;
    logic       overflow;
    logic       clear_overflow;

    int n_vec  = 0;
    int n_miss = 0;

    logic [3:0] sb [$];

    key_events #(
        .DEBOUNCE_CYCLES (DEB),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .keys           (keys),
        .keys_stable    (keys_stable),
        .event_valid    (event_valid),
        .event_key      (event_key),
        .event_press    (event_press),
        .event_ready    (event_ready),
        .event_count    (event_count),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge and are sampled here
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic exp_ev(input logic press, input int key);
        sb.push_back({press, 3'(key)});
    endtask

    // Scoreboard: a handshake seen at the falling edge pops on the next rising edge
    always @(negedge clock) begin
        if (!reset && event_valid && event_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", {28'd0, event_press, event_key}, 99);
            end else begin
                chk("event", {28'd0, event_press, event_key}, {28'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        logic [7:0] cur;
        logic [7:0] nxt;

        reset          = 1'b1;
        keys           = 8'h00;
        event_ready    = 1'b0;
        clear_overflow = 1'b0;
        repeat (2) tick();
        chk("rst_stable", keys_stable, 0);
        chk("rst_valid", event_valid, 0);
        chk("rst_count", event_count, 0);
        chk("rst_key", event_key, 0);
        chk("rst_press", event_press, 0);
        chk("rst_ovf", overflow, 0);
        reset = 1'b0;
        tick();

        // ---------------- Bounce rejection ----------------
        for (int p = 0; p < 5; p++) begin
            keys[2] = 1'b1;
            repeat (7) tick();
            chk("bounce_hi_valid", event_valid, 0);
            keys[2] = 1'b0;
            repeat (7) tick();
            chk("bounce_lo_stable", keys_stable, 0);
        end
        keys[2] = 1'b1;
        for (int e = 1; e <= DEB; e++) begin
            tick();
            chk("bounce_flip_edge", keys_stable[2], (e == DEB) ? 1 : 0);
        end
        chk("bounce_valid_at_flip", event_valid, 0);
        tick();
        chk("bounce_valid_after_push", event_valid, 1);
        chk("bounce_key", event_key, 2);
        chk("bounce_press", event_press, 1);
        exp_ev(1'b1, 2);
        event_ready = 1'b1;
        repeat (3) tick();
        keys = 8'h00;
        exp_ev(1'b0, 2);
        repeat (14) tick();
        chk("bounce_drained", event_count, 0);

        // ---------------- Simultaneous flips ----------------
        event_ready = 1'b0;
        keys = 8'hA5;
        repeat (14) tick();
        chk("simul_count", event_count, 4);
        chk("simul_ovf", overflow, 0);
        exp_ev(1'b1, 0); exp_ev(1'b1, 2); exp_ev(1'b1, 5); exp_ev(1'b1, 7);
        event_ready = 1'b1;
        repeat (6) tick();
        chk("simul_empty", event_count, 0);
        keys = 8'h00;
        exp_ev(1'b0, 0); exp_ev(1'b0, 2); exp_ev(1'b0, 5); exp_ev(1'b0, 7);
        repeat (20) tick();
        chk("simul_rel_done", sb.size(), 0);

        // ---------------- Overflow ----------------
        event_ready = 1'b0;
        keys = 8'h3F;
        repeat (20) tick();
        chk("ovf_count", event_count, 4);
        chk("ovf_flag", overflow, 1);
        exp_ev(1'b1, 0); exp_ev(1'b1, 1); exp_ev(1'b1, 2); exp_ev(1'b1, 3);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("ovf_cleared", overflow, 0);
        event_ready = 1'b1;
        repeat (6) tick();
        chk("ovf_drained", event_count, 0);
        keys = 8'h00;
        for (int k = 0; k < 6; k++) exp_ev(1'b0, k);
        repeat (20) tick();
        chk("ovf_rel_done", sb.size(), 0);

        // ---------------- Full push/pop ----------------
        event_ready = 1'b0;
        for (int k = 0; k < 5; k++) exp_ev(1'b1, k);
        keys = 8'h0F;
        repeat (14) tick();
        chk("full_count", event_count, 4);
        keys = 8'h1F;
        repeat (DEB) tick();
        chk("full_flip", keys_stable, 8'h1F);
        event_ready = 1'b1;
        tick();
        event_ready = 1'b0;
        chk("full_pp_count", event_count, 4);
        chk("full_pp_ovf", overflow, 0);
        chk("full_pp_head", event_key, 1);
        event_ready = 1'b1;
        repeat (8) tick();
        chk("full_drained", event_count, 0);
        keys = 8'h00;
        for (int k = 0; k < 5; k++) exp_ev(1'b0, k);
        repeat (20) tick();
        chk("full_rel_done", sb.size(), 0);

        // ---------------- Reset mid-operation ----------------
        event_ready = 1'b0;
        keys = 8'h0B;
        repeat (14) tick();
        chk("rstmid_count", event_count, 3);
        keys = 8'h02;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstmid_valid", event_valid, 0);
        chk("rstmid_stable", keys_stable, 0);
        chk("rstmid_count0", event_count, 0);
        for (int e = 1; e <= DEB; e++) begin
            tick();
            chk("rstmid_reflip", keys_stable[1], (e == DEB) ? 1 : 0);
        end
        exp_ev(1'b1, 1);
        event_ready = 1'b1;
        repeat (4) tick();
        keys = 8'h00;
        exp_ev(1'b0, 1);
        repeat (14) tick();
        chk("rstmid_done", sb.size(), 0);

        // ---------------- Streaming ----------------
        event_ready = 1'b1;
        cur = 8'h00;
        for (int it = 0; it < 30; it++) begin
            nxt  = 8'($urandom_range(0, 255));
            keys = nxt;
            for (int k = 0; k < 8; k++) begin
                if (nxt[k] != cur[k]) exp_ev(nxt[k], k);
            end
            repeat (2 * DEB + 2) tick();
            chk("stream_stable", keys_stable, nxt);
            cur = nxt;
        end
        chk("stream_ovf", overflow, 0);
        chk("stream_done", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
